// File: rtl/scsi_pkg.sv
// Shared types and constants for the SCSI CD target.
// Holds the bus phase and sequencer state encodings, the CDB length decode and the status/message codes.
// No logic of its own; the helper function is purely combinational.
package scsi_pkg;

    // Bus phase as driven on {MSG, C/D, I/O}
    typedef enum logic [2:0] {
        PH_NONE     = 3'b000,
        PH_DATA_IN  = 3'b001,
        PH_COMMAND  = 3'b010,
        PH_STATUS   = 3'b011,
        PH_MSG_IN   = 3'b111
    } phase_e;

    // Sequencer states; *_REQ holds REQ until ACK, *_ACK waits for ACK release
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CMD_REQ,
        ST_CMD_ACK,
        ST_EXEC,
        ST_DATA_REQ,
        ST_DATA_ACK,
        ST_STAT_REQ,
        ST_STAT_ACK,
        ST_MSG_REQ,
        ST_MSG_ACK,
        ST_FREE
    } state_e;

    localparam logic [7:0] GOOD             = 8'h00;
    localparam logic [7:0] CHECK_CONDITION  = 8'h02;
    localparam logic [7:0] MSG_CMD_COMPLETE = 8'h00;

    localparam int CDB_MAX_BYTES = 12;

    // CDB length in bytes from the opcode group (opcode[7:5])
    function automatic logic [3:0] cdb_len(input logic [2:0] grp);
        logic [3:0] len;
        case (grp)
            3'd0, 3'd3, 3'd4: len = 4'd6;
            3'd5:             len = 4'd12;
            default:          len = 4'd10;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Generic synchronous FIFO holding the DATA IN bytes.
// Head is visible combinationally; a push is stored on the next edge.
// Writes while full and reads while empty are ignored; the owner decides what a drop means.
module byte_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_en,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = i_wr_en & ~o_full;
    assign w_pop   = i_rd_en & ~o_empty;
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    // Pointer update; a synchronous clear empties the FIFO without touching storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until the pointers say otherwise
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_dat;
    end

endmodule

// File: rtl/scsi_cd_target.sv
// Target-side SCSI phase sequencer: selection, CDB collection, DATA IN from a byte FIFO, STATUS and MESSAGE IN.
// Each bus byte costs one REQ/ACK handshake plus two cycles of ACK synchroniser delay per edge.
// The initiator paces the bus via ACK; back-end bytes arriving while the FIFO is full are dropped and flagged.
module scsi_cd_target
    import scsi_pkg::*;
#(
    parameter int TARGET_ID  = 2,
    parameter int FIFO_DEPTH = 32
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        SCSI_SEL,
    input  logic        SCSI_ACK,
    input  logic        SCSI_RST,
    input  logic [7:0]  SCSI_DB_I,
    output logic        SCSI_BSY,
    output logic        SCSI_REQ,
    output logic        SCSI_CD,
    output logic        SCSI_IO,
    output logic        SCSI_MSG,
    output logic [7:0]  SCSI_DB_O,
    output logic [95:0] COMMAND,
    output logic        COMM_SEND,
    input  logic        STAT_GET,
    input  logic [7:0]  STATUS,
    input  logic [7:0]  CD_DATA,
    input  logic        CD_WR,
    output logic        DATA_OVF
);
    logic r_sel_meta, r_sel_sync;
    logic r_ack_meta, r_ack_sync;
    logic r_rst_meta, r_rst_sync;

    state_e                       r_state;
    phase_e                       r_phase;
    logic                         r_bsy;
    logic                         r_req;
    logic                         r_comm_send;
    logic [7:0]                   r_db_o;
    logic [CDB_MAX_BYTES*8-1:0]   r_command;
    logic [3:0]                   r_cdb_len;
    logic [3:0]                   r_cdb_idx;
    logic [7:0]                   r_status;
    logic                         r_stat_pend;
    logic                         r_data_ovf;

    logic       w_open;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;

    // Bring the initiator's asynchronous control lines into the CLK domain
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            r_sel_meta <= 1'b0;
            r_sel_sync <= 1'b0;
            r_ack_meta <= 1'b0;
            r_ack_sync <= 1'b0;
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_sel_meta <= SCSI_SEL;
            r_sel_sync <= r_sel_meta;
            r_ack_meta <= SCSI_ACK;
            r_ack_sync <= r_ack_meta;
            r_rst_meta <= SCSI_RST;
            r_rst_sync <= r_rst_meta;
        end
    end

    // Back-end traffic is only meaningful once the command has been handed over
    always_comb begin
        w_open = 1'b0;
        case (r_state)
            ST_EXEC, ST_DATA_REQ, ST_DATA_ACK,
            ST_STAT_REQ, ST_STAT_ACK,
            ST_MSG_REQ, ST_MSG_ACK:  w_open = 1'b1;
            default:                 w_open = 1'b0;
        endcase
    end

    assign w_push = CD_WR & w_open;
    // Pop exactly once per byte: the cycle the synchronised ACK is first seen high against our REQ
    assign w_pop  = (r_state == ST_DATA_REQ) & r_req & r_ack_sync;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk    (CLK),
        .i_rst_n  (RESn),
        .i_clr    (r_rst_sync),
        .i_wr_en  (w_push),
        .i_wr_dat (CD_DATA),
        .i_rd_en  (w_pop),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_head   (w_head)
    );

    // Bus phase sequencer; phase and data are set while REQ is low, REQ rises a cycle later
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            r_state     <= ST_IDLE;
            r_phase     <= PH_NONE;
            r_bsy       <= 1'b0;
            r_req       <= 1'b0;
            r_comm_send <= 1'b0;
            r_db_o      <= 8'h00;
            r_command   <= '0;
            r_cdb_len   <= 4'd6;
            r_cdb_idx   <= 4'd0;
        end else if (r_rst_sync) begin
            r_state     <= ST_IDLE;
            r_phase     <= PH_NONE;
            r_bsy       <= 1'b0;
            r_req       <= 1'b0;
            r_comm_send <= 1'b0;
            r_db_o      <= 8'h00;
            r_command   <= '0;
            r_cdb_len   <= 4'd6;
            r_cdb_idx   <= 4'd0;
        end else begin
            r_comm_send <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_sel_sync && SCSI_DB_I[TARGET_ID] && !r_bsy) begin
                        r_bsy     <= 1'b1;
                        r_command <= '0;
                        r_cdb_idx <= 4'd0;
                        r_cdb_len <= 4'd6;
                        r_state   <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (!r_sel_sync) begin
                        r_phase <= PH_COMMAND;
                        r_state <= ST_CMD_REQ;
                    end
                end
                ST_CMD_REQ: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (r_ack_sync) begin
                        r_command[{r_cdb_idx, 3'b000} +: 8] <= SCSI_DB_I;
                        if (r_cdb_idx == 4'd0) r_cdb_len <= cdb_len(SCSI_DB_I[7:5]);
                        r_cdb_idx <= r_cdb_idx + 4'd1;
                        r_req     <= 1'b0;
                        r_state   <= ST_CMD_ACK;
                    end
                end
                ST_CMD_ACK: begin
                    if (!r_ack_sync) begin
                        if (r_cdb_idx == r_cdb_len) begin
                            r_comm_send <= 1'b1;
                            r_state     <= ST_EXEC;
                        end else begin
                            r_state <= ST_CMD_REQ;
                        end
                    end
                end
                ST_EXEC: begin
                    // Buffered data always goes out before status
                    if (!w_empty) begin
                        r_phase <= PH_DATA_IN;
                        r_state <= ST_DATA_REQ;
                    end else if (r_stat_pend) begin
                        r_phase <= PH_STATUS;
                        r_db_o  <= r_status;
                        r_state <= ST_STAT_REQ;
                    end
                end
                ST_DATA_REQ: begin
                    if (!r_req) begin
                        r_db_o <= w_head;
                        r_req  <= 1'b1;
                    end else if (r_ack_sync) begin
                        r_req   <= 1'b0;
                        r_state <= ST_DATA_ACK;
                    end
                end
                ST_DATA_ACK: begin
                    if (!r_ack_sync) r_state <= ST_EXEC;
                end
                ST_STAT_REQ: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (r_ack_sync) begin
                        r_req   <= 1'b0;
                        r_state <= ST_STAT_ACK;
                    end
                end
                ST_STAT_ACK: begin
                    if (!r_ack_sync) begin
                        r_phase <= PH_MSG_IN;
                        r_db_o  <= MSG_CMD_COMPLETE;
                        r_state <= ST_MSG_REQ;
                    end
                end
                ST_MSG_REQ: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (r_ack_sync) begin
                        r_req   <= 1'b0;
                        r_state <= ST_MSG_ACK;
                    end
                end
                ST_MSG_ACK: begin
                    if (!r_ack_sync) r_state <= ST_FREE;
                end
                ST_FREE: begin
                    r_bsy   <= 1'b0;
                    r_phase <= PH_NONE;
                    r_db_o  <= 8'h00;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Status latch and overflow flag live until the bus is released
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            r_status    <= GOOD;
            r_stat_pend <= 1'b0;
            r_data_ovf  <= 1'b0;
        end else if (r_rst_sync || (r_state == ST_FREE)) begin
            r_stat_pend <= 1'b0;
            r_data_ovf  <= 1'b0;
        end else begin
            if (STAT_GET && w_open) begin
                r_status    <= STATUS;
                r_stat_pend <= 1'b1;
            end
            if (w_push && w_full) r_data_ovf <= 1'b1;
        end
    end

    assign SCSI_BSY  = r_bsy;
    assign SCSI_REQ  = r_req;
    assign SCSI_MSG  = r_phase[2];
    assign SCSI_CD   = r_phase[1];
    assign SCSI_IO   = r_phase[0];
    assign SCSI_DB_O = r_db_o;
    assign COMMAND   = r_command;
    assign COMM_SEND = r_comm_send;
    assign DATA_OVF  = r_data_ovf;

endmodule

// File: tb/tb_scsi_cd_target.sv
module tb_scsi_cd_target;
    typedef logic [7:0] bq_t[$];

    logic        CLK = 1'b0;
    logic        RESn = 1'b0;
    logic        SCSI_SEL = 1'b0;
    logic        SCSI_ACK = 1'b0;
    logic        SCSI_RST = 1'b0;
    logic [7:0]  SCSI_DB_I;
    logic        SCSI_BSY, SCSI_REQ, SCSI_CD, SCSI_IO, SCSI_MSG;
    logic [7:0]  SCSI_DB_O;
    logic [95:0] COMMAND;
    logic        COMM_SEND;
    logic        STAT_GET = 1'b0;
    logic [7:0]  STATUS = 8'h00;
    logic [7:0]  CD_DATA = 8'h00;
    logic        CD_WR = 1'b0;
    logic        DATA_OVF;

    // Selection data comes from the main sequence, command bytes from the initiator model
    logic        sel_drv = 1'b0;
    logic [7:0]  sel_db = 8'h00;
    logic [7:0]  ini_db = 8'h00;
    assign SCSI_DB_I = sel_drv ? sel_db : ini_db;

    scsi_cd_target #(.TARGET_ID(2), .FIFO_DEPTH(32)) dut (
        .CLK(CLK), .RESn(RESn), .SCSI_SEL(SCSI_SEL), .SCSI_ACK(SCSI_ACK), .SCSI_RST(SCSI_RST),
        .SCSI_DB_I(SCSI_DB_I), .SCSI_BSY(SCSI_BSY), .SCSI_REQ(SCSI_REQ), .SCSI_CD(SCSI_CD),
        .SCSI_IO(SCSI_IO), .SCSI_MSG(SCSI_MSG), .SCSI_DB_O(SCSI_DB_O), .COMMAND(COMMAND),
        .COMM_SEND(COMM_SEND), .STAT_GET(STAT_GET), .STATUS(STATUS), .CD_DATA(CD_DATA),
        .CD_WR(CD_WR), .DATA_OVF(DATA_OVF)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int ack_delay = 0;
    int cmd_req_cnt = 0;
    int data_cnt = 0;
    logic [10:0] exp_bus[$];
    logic [95:0] exp_cmd[$];
    logic [7:0]  cmd_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [110:0] all_outs();
        return {COMMAND, SCSI_BSY, SCSI_REQ, SCSI_CD, SCSI_IO, SCSI_MSG, SCSI_DB_O, COMM_SEND, DATA_OVF};
    endfunction

    // Initiator: answers every REQ with ACK after ack_delay cycles, supplying CDB bytes in COMMAND phase
    initial begin : initiator
        forever begin
            @(negedge CLK);
            if (SCSI_REQ && !SCSI_ACK) begin
                if (!SCSI_IO && cmd_q.size() > 0) ini_db = cmd_q.pop_front();
                repeat (ack_delay) @(negedge CLK);
                SCSI_ACK = 1'b1;
                for (int k = 0; k < 200 && SCSI_REQ; k++) @(negedge CLK);
                SCSI_ACK = 1'b0;
            end
        end
    end

    // Monitor: compares each target-to-initiator byte and each COMM_SEND against the scoreboard
    initial begin : monitor
        logic       prev_req;
        logic [2:0] prev_ph;
        prev_req = 1'b0;
        prev_ph  = 3'b000;
        forever begin
            @(negedge CLK);
            if (SCSI_REQ && prev_req)
                check("phase_stable_under_req", {SCSI_MSG, SCSI_CD, SCSI_IO}, prev_ph);
            if (SCSI_REQ && !prev_req) begin
                if (!SCSI_IO) cmd_req_cnt++;
                else begin
                    if ({SCSI_MSG, SCSI_CD, SCSI_IO} == 3'b001) data_cnt++;
                    if (exp_bus.size() == 0) begin
                        total++; bad++;
                        $display("FAIL bus_byte_unexpected: got 0x%0h, expected none",
                                 {SCSI_MSG, SCSI_CD, SCSI_IO, SCSI_DB_O});
                    end else
                        check("bus_byte", {SCSI_MSG, SCSI_CD, SCSI_IO, SCSI_DB_O}, exp_bus.pop_front());
                end
            end
            if (COMM_SEND) begin
                if (exp_cmd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL comm_send_unexpected: got 0x%0h, expected none", COMMAND);
                end else
                    check("command", COMMAND, exp_cmd.pop_front());
            end
            prev_req = SCSI_REQ;
            prev_ph  = {SCSI_MSG, SCSI_CD, SCSI_IO};
        end
    end

    task automatic select(input logic [7:0] db, output bit ok);
        sel_db = db; sel_drv = 1'b1; SCSI_SEL = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (SCSI_BSY) begin ok = 1'b1; break; end
        end
        SCSI_SEL = 1'b0;
        @(negedge CLK);
        sel_drv = 1'b0;
    endtask

    task automatic wait_comm_send(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge CLK);
            if (COMM_SEND) begin seen = 1'b1; break; end
        end
        check({tag, "_comm_send"}, seen, 1'b1);
    endtask

    // One full command: selection, CDB, back-end data + status, and bus free
    task automatic run_txn(input string tag, input bq_t cdb, input bq_t dat, input int n_deliver,
                           input logic [7:0] st);
        bit ok;
        bit seen;
        int c0;
        logic [95:0] ecmd = '0;
        foreach (cdb[i]) ecmd[i*8 +: 8] = cdb[i];
        exp_cmd.push_back(ecmd);
        foreach (cdb[i]) cmd_q.push_back(cdb[i]);
        for (int i = 0; i < n_deliver; i++) exp_bus.push_back({3'b001, dat[i]});
        exp_bus.push_back({3'b011, st});
        exp_bus.push_back({3'b111, 8'h00});
        c0 = cmd_req_cnt;
        select(8'h84, ok);
        check({tag, "_select_bsy"}, ok, 1'b1);
        wait_comm_send(tag);
        check({tag, "_cdb_byte_count"}, cmd_req_cnt - c0, cdb.size());
        check({tag, "_cdb_all_consumed"}, cmd_q.size(), 0);
        // Final data byte shares its cycle with STAT_GET
        if (dat.size() == 0) begin
            STAT_GET = 1'b1; STATUS = st;
            @(negedge CLK);
        end else begin
            foreach (dat[i]) begin
                CD_DATA = dat[i]; CD_WR = 1'b1;
                if (i == dat.size() - 1) begin STAT_GET = 1'b1; STATUS = st; end
                @(negedge CLK);
            end
        end
        CD_WR = 1'b0; STAT_GET = 1'b0;
        @(negedge CLK);
        check({tag, "_data_ovf_during"}, DATA_OVF, dat.size() > n_deliver);
        seen = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            if (!SCSI_BSY) begin seen = 1'b1; break; end
            @(negedge CLK);
        end
        check({tag, "_bus_free"}, seen, 1'b1);
        check({tag, "_all_bytes_seen"}, exp_bus.size(), 0);
        check({tag, "_idle_outputs"}, {SCSI_REQ, SCSI_CD, SCSI_IO, SCSI_MSG, DATA_OVF}, 5'b0);
        repeat (4) @(negedge CLK);
    endtask

    initial begin : watchdog
        #3000000;
        total++; bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : main
        bq_t none;
        bq_t sense;
        bq_t big;
        bit ok;
        bit hit;
        int d0;
        int c0;
        none = {};

        repeat (3) @(negedge CLK);
        check("reset_outputs", all_outs(), '0);
        RESn = 1'b1;
        repeat (3) @(negedge CLK);

        // TEST UNIT READY with CHECK CONDITION
        run_txn("tur", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, none, 0, 8'h02);

        // REQUEST SENSE returning 18 bytes
        sense = '{8'h70, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn("sense", '{8'h03, 8'h00, 8'h00, 8'h00, 8'h12, 8'h00}, sense, 18, 8'h00);

        // CDB lengths by group; the 12-byte one first so stale upper bytes would show
        run_txn("grp5", '{8'hA8, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                          8'h88, 8'h99, 8'hAA, 8'hBB}, none, 0, 8'h00);
        run_txn("grp1", '{8'h28, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                          8'h08, 8'h09}, '{8'hDE, 8'hAD}, 2, 8'h00);
        run_txn("grp6", '{8'hD8, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7,
                          8'hF8, 8'hF9}, none, 0, 8'h02);

        // Slow initiator: 40 pushes into 32 entries, bytes 32..39 are lost
        big = {};
        for (int i = 0; i < 40; i++) big.push_back(8'(i + 8'h40));
        ack_delay = 50;
        run_txn("ovf", '{8'h08, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00}, big, 32, 8'h00);
        ack_delay = 0;

        // Selection on another ID must be ignored
        sel_db = 8'h81; sel_drv = 1'b1; SCSI_SEL = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (SCSI_BSY || SCSI_REQ) hit = 1'b1;
        end
        check("wrong_id_no_response", hit, 1'b0);
        SCSI_SEL = 1'b0;
        repeat (4) @(negedge CLK);
        sel_drv = 1'b0;

        // Bus reset in the middle of DATA IN
        exp_cmd.push_back('0);
        for (int i = 0; i < 6; i++) cmd_q.push_back(8'h00);
        for (int i = 0; i < 10; i++) exp_bus.push_back({3'b001, 8'(8'hC0 + i)});
        select(8'h84, ok);
        check("rst_select_bsy", ok, 1'b1);
        wait_comm_send("rst");
        ack_delay = 5;
        d0 = data_cnt;
        for (int i = 0; i < 10; i++) begin
            CD_DATA = 8'(8'hC0 + i); CD_WR = 1'b1;
            @(negedge CLK);
        end
        CD_WR = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (data_cnt >= d0 + 3) begin hit = 1'b1; break; end
            @(negedge CLK);
        end
        check("rst_data_in_progress", hit, 1'b1);
        SCSI_RST = 1'b1;
        repeat (4) @(negedge CLK);
        check("scsi_rst_outputs", all_outs(), '0);
        SCSI_RST = 1'b0;
        repeat (6) @(negedge CLK);
        exp_bus.delete();
        ack_delay = 0;
        // Leftover FIFO bytes would appear ahead of the status byte here
        run_txn("after_rst", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, none, 0, 8'h02);

        // Hard reset in the middle of the CDB
        exp_cmd.push_back('0);
        for (int i = 0; i < 10; i++) cmd_q.push_back(8'(8'h28 + i));
        ack_delay = 3;
        c0 = cmd_req_cnt;
        select(8'h84, ok);
        check("resn_select_bsy", ok, 1'b1);
        hit = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (cmd_req_cnt >= c0 + 4) begin hit = 1'b1; break; end
            @(negedge CLK);
        end
        check("resn_cmd_in_progress", hit, 1'b1);
        RESn = 1'b0;
        @(negedge CLK);
        check("resn_outputs", all_outs(), '0);
        repeat (2) @(negedge CLK);
        RESn = 1'b1;
        repeat (20) @(negedge CLK);
        cmd_q.delete();
        exp_cmd.delete();
        ack_delay = 0;
        repeat (4) @(negedge CLK);
        run_txn("after_resn", '{8'h12, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00},
                '{8'h05, 8'h80, 8'h02}, 3, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scsi_cd_target.md
Name: scsi_cd_target

Overview:
- Target-side SCSI bus phase sequencer for the CD drive.
- Sits directly upstream of the CD command back-end and drives the SCSI bus for it:
  - answers selection and collects CDB bytes with REQ/ACK;
  - presents the CDB as COMMAND plus a one-cycle COMM_SEND;
  - buffers the back-end's CD_DATA/CD_WR stream into a FIFO and serves it in DATA IN;
  - on STAT_GET, runs STATUS then MESSAGE IN (0x00) and releases the bus.

Parameters:
TARGET_ID, 2, SCSI ID bit this target answers on the data bus during selection.
FIFO_DEPTH, 32, DATA IN buffer depth in bytes; must be a power of two and at least 18.

Ports:
CLK  in  1  system clock
RESn  in  1  asynchronous active-low reset
SCSI_SEL  in  1  SEL from initiator, active high, asynchronous to CLK
SCSI_ACK  in  1  ACK from initiator, active high, asynchronous to CLK
SCSI_RST  in  1  bus reset, active high, asynchronous to CLK
SCSI_DB_I  in  8  bus data from initiator
SCSI_BSY  out  1  BSY
SCSI_REQ  out  1  REQ
SCSI_CD  out  1  C/D
SCSI_IO  out  1  I/O
SCSI_MSG  out  1  MSG
SCSI_DB_O  out  8  bus data to initiator
COMMAND  out  96  CDB, byte n at bits [8n+7:8n]; unused bytes are 0
COMM_SEND  out  1  one-cycle strobe; COMMAND is valid in the same cycle
STAT_GET  in  1  back-end status strobe
STATUS  in  8  status byte, sampled when STAT_GET=1
CD_DATA  in  8  back-end data byte
CD_WR  in  1  byte write qualifier; each cycle with CD_WR=1 pushes CD_DATA
DATA_OVF  out  1  sticky flag: a byte was dropped because the FIFO was full

Behaviour:
- Reset and synchronisation:
  - RESn=0 asynchronously clears all outputs to 0, empties the FIFO and returns the FSM to IDLE.
  - SEL, ACK and RST each pass through a 2-FF synchroniser; all decisions use the synchronised values.
  - Synchronised RST=1 has the same effect as reset, applied synchronously, in any state.
- Phase encoding {MSG,CD,IO}: COMMAND=010, DATA IN=001, STATUS=011, MESSAGE IN=111. Phase outputs change only while REQ=0.
- IDLE -> SELECT: when SEL=1, SCSI_DB_I[TARGET_ID]=1 and BSY=0. The next cycle asserts BSY.
- SELECT: wait for SEL=0, then go to CMD.
- CMD (one byte per handshake):
  - Assert REQ. On ACK=1, store SCSI_DB_I as the next CDB byte and drop REQ. On ACK=0, advance.
  - Byte 0 sets the CDB length from opcode[7:5]: group 0/3/4 = 6, group 1/2/6/7 = 10, group 5 = 12.
  - After the last byte, pulse COMM_SEND for one cycle and go to EXEC.
  - The COMMAND register is cleared at selection.
- EXEC:
  - FIFO not empty -> DATA; enter DATA IN phase.
  - FIFO empty and status latched -> STAT.
- DATA:
  - Per byte: drive the FIFO head on DB_O, assert REQ. On ACK=1, drop REQ and pop. On ACK=0, return to EXEC.
  - The phase stays DATA IN across consecutive bytes.
- Status latch:
  - STAT_GET=1 in any state after COMM_SEND latches STATUS and sets status-pending.
  - Status is served only after the FIFO drains.
  - A CD_WR push in the same cycle as STAT_GET is accepted and served first.
- STAT: send the latched status with one REQ/ACK cycle, then go to MSG.
- MSG: send 0x00 with one REQ/ACK cycle, then go to FREE.
- FREE: clear BSY, the phase outputs, status-pending and DATA_OVF; go to IDLE.
- FIFO:
  - Push when CD_WR=1 and not full; pop on the ACK rising edge in DATA.
  - A push and a pop in the same cycle are both honoured.
  - A push while full drops the byte and sets DATA_OVF.
  - Pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally, and full/empty is decided by the MSB comparison.
- CD_WR or STAT_GET arriving in IDLE/SELECT/CMD is ignored.
- SEL reasserted while BSY=1 is ignored.

Decomposition:
- Package scsi_pkg:
  - phase enum;
  - FSM state enum;
  - group-to-CDB-length function;
  - status and message constants GOOD=0x00, CHECK_CONDITION=0x02, MSG_CMD_COMPLETE=0x00.
- Sub-module byte_fifo: parameterised synchronous FIFO with async active-low reset, outputs full, empty and head.

Test Plan:
- Select TARGET_ID, send CDB 00 00 00 00 00 00 -> COMM_SEND pulses once with COMMAND=0x...000000000000. Back-end returns STAT_GET with STATUS=0x02 -> bus shows STATUS byte 0x02 at phase 011, then 0x00 at phase 111, then BSY=0.
- CDB 03 00 00 00 12 00 with an 18-byte response 70 00 02 00 00 00 00 0A 00 00 00 00 0B 00 00 00 00 00 -> DATA IN delivers those 18 bytes in order, then STATUS 0x00.
- Opcode 0x28 -> exactly 10 command bytes collected. Opcode 0xA8 -> exactly 12. Opcode 0xD8 -> exactly 10. COMMAND bytes beyond the CDB length read 0.
- Slow initiator (ACK latency 50 cycles) with 40 pushes and FIFO_DEPTH=32 -> DATA_OVF=1, exactly 32 bytes delivered, STATUS still served; DATA_OVF clears at bus free.
- Selection with SCSI_DB_I bit 2 clear -> BSY stays 0 and no REQ is issued.
- SCSI_RST pulse mid-DATA IN, and RESn pulse mid-CMD -> all outputs 0 and the FIFO empty. The next selection and command then complete normally.
